// File: rtl/piso_serializer.sv
// piso_serializer -- parallel-in, serial-out transmitter.
//
// Takes a WIDTH-bit word over a valid/ready load handshake and shifts it out
// MSB first, one bit per clock. ser_valid qualifies every frame bit and
// ser_last marks the final bit of each frame. A handshake accepted in the
// final frame cycle chains the next frame with no idle gap.
//
// Optional feature macro: PIS_PARITY_EN
//   defined   : an even-parity bit (XOR of the data bits, captured at the
//               handshake) follows the LSB, and ser_last marks that bit.
//   undefined : the frame is exactly WIDTH bits and ser_last marks the LSB.
//
// Ports:
//   clk         in   rising-edge clock
//   clr         in   synchronous active-high reset
//   load_data   in   [WIDTH-1:0] word to transmit, sampled only on handshake
//   load_valid  in   load_data is valid
//   load_ready  out  word can be accepted this cycle (combinational)
//   ser_out     out  serial data bit (registered)
//   ser_valid   out  ser_out carries a frame bit (registered)
//   ser_last    out  final bit of the current frame (registered)
//   busy        out  a frame is in progress (mirrors ser_valid)

module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef PIS_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_SHIFT  = 2'd1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_shift, w_shift_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_ser_out, w_ser_out_next;
  logic             r_ser_valid, w_ser_valid_next;
  logic             r_ser_last, w_ser_last_next;
  logic             w_final;
  logic             w_hs;
`ifdef PIS_PARITY_EN
  logic             r_parity, w_parity_next;
`endif

  // Final frame cycle: the one cycle of a frame in which a new word may be
  // accepted so that the next frame follows without a gap.
  always_comb begin
`ifdef PIS_PARITY_EN
    w_final = (r_state == S_PARITY);
`else
    w_final = (r_state == S_SHIFT) && (r_cnt == '0);
`endif
    load_ready = !clr && ((r_state == S_IDLE) || w_final);
    w_hs       = load_valid && load_ready;
  end

  // Next-state and next-output decode. The output flops are loaded from the
  // next-state values so that ser_out/ser_valid/ser_last come straight off
  // registers while still lining up with the state they describe.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
`ifdef PIS_PARITY_EN
    w_parity_next = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_state_next = S_IDLE;
      end
      S_SHIFT: begin
        w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end else begin
`ifdef PIS_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef PIS_PARITY_EN
      S_PARITY: begin
        w_state_next = S_IDLE;
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A handshake overrides the normal progression; it can only happen in
    // IDLE or the final frame cycle, so nothing in flight is lost.
    if (w_hs) begin
      w_state_next = S_SHIFT;
      w_shift_next = load_data;
      w_cnt_next   = CNT_LOAD;
`ifdef PIS_PARITY_EN
      w_parity_next = ^load_data;
`endif
    end

    w_ser_valid_next = (w_state_next != S_IDLE);
    w_ser_out_next   = 1'b0;
    w_ser_last_next  = 1'b0;
    if (w_state_next == S_SHIFT) begin
      w_ser_out_next = w_shift_next[WIDTH-1];
`ifndef PIS_PARITY_EN
      w_ser_last_next = (w_cnt_next == '0);
`endif
    end
`ifdef PIS_PARITY_EN
    if (w_state_next == S_PARITY) begin
      w_ser_out_next  = w_parity_next;
      w_ser_last_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
`ifdef PIS_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_cnt       <= w_cnt_next;
      r_ser_out   <= w_ser_out_next;
      r_ser_valid <= w_ser_valid_next;
      r_ser_last  <= w_ser_last_next;
`ifdef PIS_PARITY_EN
      r_parity    <= w_parity_next;
`endif
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign ser_last  = r_ser_last;
  assign busy      = r_ser_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=8).
// Reference model: every accepted word expands into a queue of {bit, last}
// frame entries; one entry is retired per clock and is what the serial
// outputs must show. load_ready is expected whenever nothing is on the
// line or the entry on the line is the last of its frame, and clr is low.

module tb_piso_serializer;

  localparam int W = 8;
`ifdef PIS_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, ser_out, ser_valid, ser_last, busy;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---- reference model state ----
  logic [1:0] q[$];    // pending {bit, last} entries
  logic       cur_v = 1'b0;
  logic       cur_b = 1'b0;
  logic       cur_l = 1'b0;

  // One clock of stimulus plus model advance. Returns packed vectors
  // {load_ready(before edge), ser_valid, ser_out, ser_last, busy}.
  task automatic cycle(input logic c, input logic lv, input logic [W-1:0] d,
                       output logic [4:0] exp, output logic [4:0] got,
                       output logic hs);
    clr = c;
    load_valid = lv;
    load_data = d;
    #1;
    exp[4] = !c && (!cur_v || cur_l);
    got[4] = load_ready;
    hs = lv && exp[4];
    @(posedge clk);
    if (c) begin
      q.delete();
    end else if (hs) begin
      for (int i = W - 1; i >= 0; i--) q.push_back({d[i], (i == 0) && !PAR});
      if (PAR) q.push_back({^d, 1'b1});
    end
    if (!c && q.size() > 0) begin
      {cur_b, cur_l} = q.pop_front();
      cur_v = 1'b1;
    end else begin
      cur_v = 1'b0; cur_b = 1'b0; cur_l = 1'b0;
    end
    @(negedge clk);
    exp[3:0] = {cur_v, cur_v & cur_b, cur_v & cur_l, cur_v};
    got[3:0] = {ser_valid, ser_out, ser_last, busy};
  endtask

  task automatic test_reset();
    logic [4:0] e, g; logic hs;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, W'($urandom), e, g, hs);
      checks++;
      if (g !== e) begin errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, g, e); end
    end
    cycle(1'b0, 1'b0, '0, e, g, hs);
    checks++;
    if (g !== e) begin errors++; $display("FAIL reset_release got=%b exp=%b", g, e); end
  endtask

  task automatic test_single_word(input logic [W-1:0] word, input string nm);
    logic [4:0] e, g; logic hs; logic [W-1:0] bits; int nv; logic pbit;
    bits = '0; nv = 0; pbit = 1'b0;
    for (int i = 0; i < FRAME + 3; i++) begin
      cycle(1'b0, i == 0, word, e, g, hs);
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s cyc=%0d got=%b exp=%b", nm, i, g, e); end
      if (ser_valid) begin
        if (nv < W) bits = {bits[W-2:0], ser_out};
        else pbit = ser_out;
        nv++;
      end
    end
    checks++;
    if (bits !== word || nv != FRAME) begin
      errors++; $display("FAIL %s_stream got=%h/%0d exp=%h/%0d", nm, bits, nv, word, FRAME);
    end
    if (PAR) begin
      checks++;
      if (pbit !== ^word) begin errors++; $display("FAIL %s_parity got=%b exp=%b", nm, pbit, ^word); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e, g; logic hs; int dut_hs, run, best;
    dut_hs = 0; run = 0; best = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cycle(1'b0, dut_hs < 2, (dut_hs == 0) ? 8'hFF : 8'h00, e, g, hs);
      if (load_valid && g[4]) dut_hs++;
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, g, e); end
      run = ser_valid ? run + 1 : 0;
      if (run > best) best = run;
    end
    checks++;
    if (dut_hs != 2 || best != 2 * FRAME) begin
      errors++; $display("FAIL b2b_count hs=%0d run=%0d exp hs=2 run=%0d", dut_hs, best, 2 * FRAME);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] e, g; logic hs; int n; logic done; int run, best;
    done = 1'b0; run = 0; best = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      // A5 handshakes at i=0; 3C is presented from frame cycle 3 until taken.
      cycle(1'b0, (i == 0) || (i >= 3 && !done), (i == 0) ? 8'hA5 : 8'h3C, e, g, hs);
      if (i >= 3 && hs) begin done = 1'b1; n = i; end
      checks++;
      if (g !== e) begin errors++; $display("FAIL backpressure cyc=%0d got=%b exp=%b", i, g, e); end
      run = ser_valid ? run + 1 : 0;
      if (run > best) best = run;
    end
    checks++;
    if (!done || n != FRAME || best != 2 * FRAME) begin
      errors++; $display("FAIL backpressure_timing hs_at=%0d run=%0d exp hs_at=%0d run=%0d", n, best, FRAME, 2 * FRAME);
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] e, g; logic hs; logic [W-1:0] bits; int nv;
    bits = '0; nv = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, i == 0, 8'hF0, e, g, hs);
      checks++;
      if (g !== e) begin errors++; $display("FAIL midreset_pre cyc=%0d got=%b exp=%b", i, g, e); end
    end
    cycle(1'b1, 1'b0, '0, e, g, hs);
    checks++;
    if (g !== e || ser_valid !== 1'b0 || ser_last !== 1'b0) begin
      errors++; $display("FAIL midreset_clr got=%b exp=%b", g, e);
    end
    for (int i = 0; i < FRAME + 2; i++) begin
      cycle(1'b0, i == 0, 8'h81, e, g, hs);
      checks++;
      if (g !== e) begin errors++; $display("FAIL midreset_post cyc=%0d got=%b exp=%b", i, g, e); end
      if (ser_valid && nv < W) begin bits = {bits[W-2:0], ser_out}; nv++; end
    end
    checks++;
    if (bits !== 8'h81) begin errors++; $display("FAIL midreset_stream got=%h exp=81", bits); end
  endtask

  task automatic test_random();
    logic [4:0] e, g; logic hs;
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, W'($urandom), e, g, hs);
      checks++;
      if (g !== e) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word(8'hA5, "single_a5");
    test_single_word(8'h07, "single_07");
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock, MSB first, on `ser_out`. Qualifying strobes `ser_valid` and `ser_last` mark each frame. It is the sending end of the serial path that the shift-register chain receives, and it supports back-to-back frames with no idle gap.

## Interface

Parameters:
- `WIDTH`, default 8: word width in bits. Legal range is 2..32.

Ports:
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  reset. Synchronous, active-high.
- `load_data`  in  WIDTH  word to transmit. Sampled only on handshake.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  the block can accept a word this cycle.
- `ser_out`  out  1  serial data bit. Registered.
- `ser_valid`  out  1  `ser_out` carries a frame bit this cycle. Registered.
- `ser_last`  out  1  final bit of the current frame. Registered.
- `busy`  out  1  a frame is in progress (`ser_valid` is high).

## Operation

- A handshake occurs on a rising edge where `load_valid` and `load_ready` are both 1. On that edge:
  - `load_data` is copied into the shift register.
  - The bit counter loads WIDTH-1.
  - The FSM enters SHIFT.
- FSM states:
  - IDLE: `ser_valid`=0, `ser_out`=0, `load_ready`=1.
  - SHIFT: `ser_out` = shift_reg[WIDTH-1], `ser_valid`=1. Each cycle the register shifts left, filling with 0, and the counter decrements. When the counter is 0, `ser_last`=1 unless parity is enabled.
  - PARITY (PARITY_EN builds only): a single cycle with `ser_out` = parity bit, `ser_valid`=1, `ser_last`=1.
- `load_ready` is combinational:
  - 1 in IDLE.
  - 1 in the final frame cycle: SHIFT with counter 0 (no parity), or PARITY.
  - 0 in every other cycle.
  - Forced to 0 while `clr`=1.
- Back-to-back frames: a handshake in the final frame cycle moves the FSM straight into SHIFT with the new word. `ser_valid` stays 1 with no gap.
- Final frame cycle with no handshake: the FSM returns to IDLE.
- `load_valid` asserted while `load_ready`=0 is ignored. No state change occurs and the upstream logic holds the word.
- `load_data` is never re-sampled mid-frame. Upstream changes during a frame have no effect.
- Bit counter width is $clog2(WIDTH). The counter does not wrap, because it is reloaded on every handshake and is only decremented in SHIFT when nonzero.

## Timing

- Reset: `clr`=1 at a rising edge forces the following values, whatever the state, including mid-frame:
  - FSM = IDLE.
  - `ser_out`=0, `ser_valid`=0, `ser_last`=0, `busy`=0.
  - Shift register and counter = 0.
  - A partially sent frame is abandoned, with no `ser_last` and no parity bit.
  - A handshake presented in the same cycle as `clr` is dropped.
- Latency: a handshake at edge N puts the MSB on `ser_out` in the cycle after edge N. The LSB appears at edge N+WIDTH-1, and the parity bit (if built) at edge N+WIDTH.
- Frame length is WIDTH cycles, or WIDTH+1 with PARITY_EN.
- Throughput is one word per frame length under continuous `load_valid`.
- All outputs except `load_ready` are registered. `load_ready` is a combinational decode of the FSM state, the counter and `clr`.

## Configuration

- `PIS_PARITY_EN` defined:
  - The PARITY state is built.
  - Even parity (XOR of all WIDTH data bits, latched at handshake) is sent as bit WIDTH+1.
  - `ser_last` marks the parity bit, not the LSB.
- `PIS_PARITY_EN` undefined:
  - The PARITY state and the parity register are absent.
  - `ser_last` marks the LSB.
  - The frame is exactly WIDTH bits.

## Test plan

All scenarios use WIDTH=8.
- Reset: hold `clr`=1 for 2 cycles with `load_valid`=1 -> all outputs 0, `load_ready`=0, no frame starts. On release -> `load_ready`=1.
- Single word, no parity: handshake 8'hA5 -> `ser_out` = 1,0,1,0,0,1,0,1 over 8 cycles with `ser_valid`=1, `ser_last`=1 on the 8th cycle only, then IDLE.
- Parity build: 8'hA5 -> 9th bit 0. 8'h07 -> 9th bit 1, with `ser_last` on the 9th bit each time.
- Back-to-back: `load_valid` held high with 8'hFF then 8'h00 -> 16 (or 18 with parity) consecutive `ser_valid` cycles and exactly two handshakes.
- Backpressure: drive `load_valid`=1 with 8'h3C during cycle 3 of an 8'hA5 frame -> no effect until the final frame cycle, then 8'h3C is sent immediately after.
- Mid-frame reset: assert `clr` at bit 4 of 8'hF0 -> `ser_valid`=0 the next cycle with no `ser_last`. A new handshake of 8'h81 afterwards -> clean frame 1,0,0,0,0,0,0,1.
